// File: rtl/vga_pkg.sv
// Shared definitions for the raster-scan / sprite path.
// Holds the default VGA 640x480 timing, the default sprite geometry, the
// coordinate and sprite-address types at those defaults, and small helper
// functions for the frame totals and the selector-id width.
package vga_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_FP_DEF        = 16;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BP_DEF        = 48;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_FP_DEF        = 10;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BP_DEF        = 33;
  localparam int NUM_SPRITES_DEF = 2;
  localparam int SPRITE_W_DEF    = 64;
  localparam int SPRITE_H_DEF    = 64;
  localparam int COORD_W_DEF     = 10;
  localparam int ADDR_W_DEF      = $clog2(SPRITE_W_DEF * SPRITE_H_DEF);

  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [ADDR_W_DEF-1:0]  sprite_addr_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // A single sprite still needs a one-bit id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_scan_gen_if.sv
// Bundle of everything the sprite scan generator exchanges with its user.
// master: the raster consumer, which drives pix_en and the sprite table and
//         receives the scan position, sync, hit and address outputs.
// slave : the generator itself.
interface sprite_scan_gen_if
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
);
  localparam int ID_W = id_width(NUM_SPRITES);

  logic                                  pix_en;
  logic [NUM_SPRITES-1:0][COORD_W-1:0]   sprite_x;
  logic [NUM_SPRITES-1:0][COORD_W-1:0]   sprite_y;
  logic [NUM_SPRITES-1:0]                sprite_en;

  logic [COORD_W-1:0]                    pixelx;
  logic [COORD_W-1:0]                    pixely;
  logic                                  hsync;
  logic                                  vsync;
  logic                                  video_on;
  logic                                  frame_start;
  logic [NUM_SPRITES-1:0]                hit;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0]    sprite_addr;
  logic                                  sel_valid;
  logic [ID_W-1:0]                       sel_id;
  logic [ADDR_W-1:0]                     sel_addr;

  modport master (
    output pix_en, sprite_x, sprite_y, sprite_en,
    input  pixelx, pixely, hsync, vsync, video_on, frame_start,
           hit, sprite_addr, sel_valid, sel_id, sel_addr
  );

  modport slave (
    input  pix_en, sprite_x, sprite_y, sprite_en,
    output pixelx, pixely, hsync, vsync, video_on, frame_start,
           hit, sprite_addr, sel_valid, sel_id, sel_addr
  );

endinterface

// File: rtl/vga_timing_counter.sv
// Pixel/line counters with registered sync, video_on and frame_start.
// Ports:
//   clk, rst (async, active-low), pix_en (advance enable)
//   pixelx/pixely, hsync/vsync (active-low), video_on, frame_start: registered
//   pixelx_nxt/pixely_nxt/video_on_nxt/frame_wrap: the values being loaded
//   at this edge, so downstream registers line up with the counters.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [COORD_W-1:0] pixelx,
  output logic [COORD_W-1:0] pixely,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start,
  output logic [COORD_W-1:0] pixelx_nxt,
  output logic [COORD_W-1:0] pixely_nxt,
  output logic               video_on_nxt,
  output logic               frame_wrap
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] pixelx_q, pixelx_d, pixely_q, pixely_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic wrap;

  always_comb begin
    // NOTE: every variable gets its default first, so no branch can leave one
    // unassigned and infer a latch.
    pixelx_d      = pixelx_q;
    pixely_d      = pixely_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    wrap          = 1'b0;
    if (pix_en) begin
      if (pixelx_q == H_LAST) begin
        pixelx_d = '0;
        if (pixely_q == V_LAST) begin
          pixely_d = '0;
          wrap     = 1'b1;
        end else begin
          pixely_d = pixely_q + COORD_W'(1);
        end
      end else begin
        pixelx_d = pixelx_q + COORD_W'(1);
      end
      // Derived outputs come from the next position so they register in
      // step with the counters.
      hsync_d       = !((pixelx_d >= HS_FIRST) && (pixelx_d <= HS_LAST));
      vsync_d       = !((pixely_d >= VS_FIRST) && (pixely_d <= VS_LAST));
      video_on_d    = (pixelx_d < H_VIS) && (pixely_d < V_VIS);
      frame_start_d = wrap;
    end
  end

  // NOTE: non-blocking assignments, so every flop samples its _d from the
  // same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixelx_q      <= '0;
      pixely_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pixelx_q      <= pixelx_d;
      pixely_q      <= pixely_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixelx       = pixelx_q;
  assign pixely       = pixely_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_on     = video_on_q;
  assign frame_start  = frame_start_q;
  assign pixelx_nxt   = pixelx_d;
  assign pixely_nxt   = pixely_d;
  assign video_on_nxt = video_on_d;
  assign frame_wrap   = wrap;

endmodule

// File: rtl/sprite_scan_gen.sv
// Raster-scan generator with a multi-sprite address unit.
// Ports:
//   clk, rst (async, active-low)
//   bus (slave): pix_en and the sprite table in; scan position, syncs,
//   video_on, frame_start, per-sprite hit/address and the priority-selected
//   sprite out. All outputs are registered and describe the current pixel.
// Sprite positions and enables are shadowed at the frame wrap so a frame
// never mixes old and new positions.
module sprite_scan_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int SPRITE_W    = SPRITE_W_DEF,
  parameter int SPRITE_H    = SPRITE_H_DEF,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int ADDR_W      = $clog2(SPRITE_W * SPRITE_H)
) (
  input logic              clk,
  input logic              rst,
  sprite_scan_gen_if.slave bus
);

  localparam int ID_W  = id_width(NUM_SPRITES);
  localparam int CMP_W = COORD_W + 1;

  logic [COORD_W-1:0] pixelx_nxt, pixely_nxt;
  logic               video_on_nxt, frame_wrap;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COORD_W (COORD_W)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (bus.pix_en),
    .pixelx      (bus.pixelx),
    .pixely      (bus.pixely),
    .hsync       (bus.hsync),
    .vsync       (bus.vsync),
    .video_on    (bus.video_on),
    .frame_start (bus.frame_start),
    .pixelx_nxt  (pixelx_nxt),
    .pixely_nxt  (pixely_nxt),
    .video_on_nxt(video_on_nxt),
    .frame_wrap  (frame_wrap)
  );

  // One bit wider than a coordinate so s+len-1 cannot wrap around and
  // make a sprite near the far edge reappear at column/line 0.
  function automatic logic in_span(input logic [COORD_W-1:0] p,
                                   input logic [COORD_W-1:0] s,
                                   input int len);
    logic [CMP_W-1:0] pe, se;
    pe = {1'b0, p};
    se = {1'b0, s};
    return (pe >= se) && (pe <= se + CMP_W'(len - 1));
  endfunction

  logic [NUM_SPRITES-1:0][COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, dx, dy;
  logic [NUM_SPRITES-1:0]              sen_q, sen_d, hit_q, hit_d;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic                                sel_valid_q, sel_valid_d;
  logic [ID_W-1:0]                     sel_id_q, sel_id_d;
  logic [ADDR_W-1:0]                   sel_addr_q, sel_addr_d;

  always_comb begin
    sx_d  = sx_q;
    sy_d  = sy_q;
    sen_d = sen_q;
    if (frame_wrap) begin
      sx_d  = bus.sprite_x;
      sy_d  = bus.sprite_y;
      sen_d = bus.sprite_en;
    end
  end

  // Hits use the shadow values being loaded this edge, so the first pixel
  // of a new frame already sees the new sprite table.
  always_comb begin
    hit_d       = hit_q;
    addr_d      = addr_q;
    sel_valid_d = sel_valid_q;
    sel_id_d    = sel_id_q;
    sel_addr_d  = sel_addr_q;
    dx          = '0;
    dy          = '0;
    if (bus.pix_en) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        dx[i]     = pixelx_nxt - sx_d[i];
        dy[i]     = pixely_nxt - sy_d[i];
        hit_d[i]  = video_on_nxt && sen_d[i] &&
                    in_span(pixelx_nxt, sx_d[i], SPRITE_W) &&
                    in_span(pixely_nxt, sy_d[i], SPRITE_H);
        addr_d[i] = hit_d[i] ? ADDR_W'(int'(dy[i]) * SPRITE_W + int'(dx[i])) : '0;
      end
      // Walk downwards so the lowest-index hit is the last one written.
      sel_id_d   = '0;
      sel_addr_d = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
        if (hit_d[i]) begin
          sel_id_d   = ID_W'(i);
          sel_addr_d = addr_d[i];
        end
      end
      sel_valid_d = |hit_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx_q        <= '0;
      sy_q        <= '0;
      sen_q       <= '0;
      hit_q       <= '0;
      addr_q      <= '0;
      sel_valid_q <= 1'b0;
      sel_id_q    <= '0;
      sel_addr_q  <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sen_q       <= sen_d;
      hit_q       <= hit_d;
      addr_q      <= addr_d;
      sel_valid_q <= sel_valid_d;
      sel_id_q    <= sel_id_d;
      sel_addr_q  <= sel_addr_d;
    end
  end

  assign bus.hit         = hit_q;
  assign bus.sprite_addr = addr_q;
  assign bus.sel_valid   = sel_valid_q;
  assign bus.sel_id      = sel_id_q;
  assign bus.sel_addr    = sel_addr_q;

endmodule

// File: tb/tb_sprite_scan_gen.sv
// Scoreboard bench for sprite_scan_gen on a shrunken raster (56x37) so whole
// frames fit in a short run. The driver advances a reference model that
// counts enabled pixels and derives position, syncs, hits and addresses
// arithmetically; one expected snapshot is queued per clock edge and a
// separate monitor pops and compares it just after that edge.
module tb_sprite_scan_gen;
  import vga_pkg::*;

  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NS = 3, SW = 8, SH = 6;
  localparam int CW = COORD_W_DEF;
  localparam int AW = $clog2(SW * SH);
  localparam int IW = id_width(NS);

  typedef struct packed {
    coord_t                 x;
    coord_t                 y;
    logic                   hs;
    logic                   vs;
    logic                   vo;
    logic                   fs;
    logic [NS-1:0]          hit;
    logic [NS-1:0][AW-1:0]  addr;
    logic                   sv;
    logic [IW-1:0]          sid;
    logic [AW-1:0]          saddr;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sprite_scan_gen_if #(.NUM_SPRITES(NS), .COORD_W(CW), .ADDR_W(AW)) bus ();

  sprite_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH),
    .COORD_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   n     = 0;
  bit   fresh = 1'b1;
  int   shx[NS];
  int   shy[NS];
  bit   shen[NS];
  int   frames_model = 0;
  int   frames_seen  = 0;
  obs_t exp_q[$];

  task automatic check(input string name, input obs_t act, input obs_t exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h (got x=%0d y=%0d, want x=%0d y=%0d)",
               name, $time, act, exp_v, act.x, act.y, exp_v.x, exp_v.y);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.x     = bus.pixelx;
    o.y     = bus.pixely;
    o.hs    = bus.hsync;
    o.vs    = bus.vsync;
    o.vo    = bus.video_on;
    o.fs    = bus.frame_start;
    o.hit   = bus.hit;
    o.addr  = bus.sprite_addr;
    o.sv    = bus.sel_valid;
    o.sid   = bus.sel_id;
    o.saddr = bus.sel_addr;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected outputs for the pixel at linear position n of the frame.
  function automatic obs_t model_obs(input bit fs);
    obs_t o;
    int x, y;
    x    = n % HT;
    y    = n / HT;
    o    = '0;
    o.x  = coord_t'(x);
    o.y  = coord_t'(y);
    o.hs = !(x >= HA + HF && x < HA + HF + HS);
    o.vs = !(y >= VA + VF && y < VA + VF + VS);
    o.vo = (x < HA) && (y < VA);
    o.fs = fs;
    for (int i = 0; i < NS; i++) begin
      if (o.vo && shen[i] && x >= shx[i] && x < shx[i] + SW &&
          y >= shy[i] && y < shy[i] + SH) begin
        o.hit[i]  = 1'b1;
        o.addr[i] = AW'(((y - shy[i]) * SW + (x - shx[i])) % (1 << AW));
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (!o.sv && o.hit[i]) begin
        o.sv    = 1'b1;
        o.sid   = IW'(i);
        o.saddr = o.addr[i];
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    n     = 0;
    fresh = 1'b1;
    for (int i = 0; i < NS; i++) begin
      shx[i]  = 0;
      shy[i]  = 0;
      shen[i] = 1'b0;
    end
  endtask

  // Called just after a falling edge: drive pix_en, queue what the next
  // rising edge must produce, then move on to the following falling edge.
  task automatic step(input bit en);
    obs_t e;
    bit   wrap;
    bus.pix_en = en;
    if (!rst) begin
      model_reset();
      e = reset_obs();
    end else if (en) begin
      wrap = (n == FRAME - 1);
      n    = wrap ? 0 : n + 1;
      if (wrap) begin
        for (int i = 0; i < NS; i++) begin
          shx[i]  = int'(bus.sprite_x[i]);
          shy[i]  = int'(bus.sprite_y[i]);
          shen[i] = bus.sprite_en[i];
        end
        frames_model++;
      end
      fresh = 1'b0;
      e     = model_obs(wrap);
    end else begin
      e = fresh ? reset_obs() : model_obs(1'b0);
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input bit en);
    bus.sprite_x[i]  = CW'(x);
    bus.sprite_y[i]  = CW'(y);
    bus.sprite_en[i] = en;
  endtask

  task automatic rand_sprite();
    int i, x;
    i = $urandom_range(0, NS - 1);
    x = ($urandom_range(0, 7) == 0) ? (1023 - $urandom_range(0, 8)) : $urandom_range(0, HT + 4);
    set_sprite(i, x, $urandom_range(0, VT), 1'($urandom_range(0, 1)));
  endtask

  // Monitor: compare one queued snapshot per rising edge.
  initial begin : monitor
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        check("pixel", a, e);
        if (a.fs === 1'b1) frames_seen++;
      end
    end
  end

  initial begin : driver
    bus.pix_en    = 1'b0;
    bus.sprite_x  = '0;
    bus.sprite_y  = '0;
    bus.sprite_en = '0;
    model_reset();

    // Held in reset, even with pix_en high.
    repeat (3) step(1'b1);
    rst = 1'b1;
    // Out of reset but not enabled: everything still holds.
    repeat (2) step(1'b0);

    // Frame 1: no sprites visible yet; sprite 0 latched at its end.
    set_sprite(0, 10, 5, 1'b1);
    for (int j = 0; j < FRAME; j++) step(1'b1);

    // Frame 2: sprite 0 alone. Overlapping sprites 1 and 2 are written
    // mid-frame and must only appear next frame.
    for (int j = 0; j < FRAME; j++) begin
      if (j == FRAME / 2) begin
        set_sprite(1, 10, 5, 1'b1);
        set_sprite(2, 13, 8, 1'b1);
      end
      step(1'b1);
    end

    // Frame 3: priority with all three; sprite 0 disabled mid-frame.
    for (int j = 0; j < FRAME; j++) begin
      if (j == FRAME / 3) bus.sprite_en[0] = 1'b0;
      step(1'b1);
    end

    // Frame 4: sprite 1 wins. Edge-clipping positions written mid-frame.
    for (int j = 0; j < FRAME; j++) begin
      if (j == FRAME / 2) begin
        set_sprite(0, 36, 20, 1'b1);
        set_sprite(1, 20, 27, 1'b1);
        set_sprite(2, 1020, 1020, 1'b1);
      end
      step(1'b1);
    end

    // Frame 5: clipped sprites, then 1-of-2 enable for about one frame.
    for (int j = 0; j < FRAME; j++) step(1'b1);
    for (int j = 0; j < 2 * FRAME; j++) step(1'(j % 2));

    // Random enable and random sprite rewrites.
    for (int j = 0; j < 4 * FRAME; j++) begin
      if ($urandom_range(0, 63) == 0) rand_sprite();
      step(1'($urandom_range(0, 1)));
    end

    // Land mid-line, then assert reset between edges.
    for (int j = 0; j < 25; j++) step(1'b1);
    bus.pix_en = 1'b1;
    #2 rst = 1'b0;
    #1 check("async_reset", sample(), reset_obs());
    model_reset();
    exp_q.push_back(reset_obs());
    @(negedge clk);
    repeat (3) step(1'b1);
    rst = 1'b1;
    for (int j = 0; j < 3 * HT; j++) step(1'b1);

    @(posedge clk);
    #2;
    check_int("queue_drained", exp_q.size(), 0);
    check_int("frame_start_count", frames_seen, frames_model);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_scan_gen.md
Name: sprite_scan_gen

Overview:
Parametrised raster-scan generator for the VGA graphics path, with a multi-sprite address unit.
- Advances pixel/line counters on a pixel-clock enable and produces active-low hsync/vsync plus video_on.
- For NUM_SPRITES sprites, produces per-sprite hit flags and sprite-ROM addresses.
- Resolves priority to a single selected sprite.
- Latches sprite positions only at frame start, so a frame never tears.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
NUM_SPRITES, 2, number of sprite channels (1..8)
SPRITE_W, 64, sprite width in pixels (power of two)
SPRITE_H, 64, sprite height in lines
COORD_W, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
ADDR_W, $clog2(SPRITE_W*SPRITE_H), sprite address width (12 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pix_en  in  1  pixel-clock enable; state advances only when high
sprite_x  in  NUM_SPRITES x COORD_W  sprite left-column positions
sprite_y  in  NUM_SPRITES x COORD_W  sprite top-line positions
sprite_en  in  NUM_SPRITES  per-sprite enable
pixelx  out  COORD_W  current column
pixely  out  COORD_W  current line
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
video_on  out  1  current pixel is in the visible region
frame_start  out  1  one-clk pulse on the wrap to (0,0)
hit  out  NUM_SPRITES  current pixel lies inside sprite i
sprite_addr  out  NUM_SPRITES x ADDR_W  per-sprite ROM address
sel_valid  out  1  at least one hit
sel_id  out  $clog2(NUM_SPRITES) (min 1)  lowest-index sprite that hit
sel_addr  out  ADDR_W  sprite_addr of sel_id

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (rst=0, asynchronous): counters = 0; shadow positions = 0; shadow enables = 0; hsync = vsync = 1; video_on = 0; frame_start = 0; hit = 0; all addresses = 0; sel_valid = 0; sel_id = 0.
- pix_en = 0: every register holds, and frame_start = 0.
- pix_en = 1, column advance: pixelx increments. At H_TOTAL-1 it wraps to 0 and pixely increments.
- pix_en = 1, line wrap: at pixelx = H_TOTAL-1 and pixely = V_TOTAL-1, both wrap to 0.
- On that frame wrap, shadow positions/enables load from sprite_x/sprite_y/sprite_en, and frame_start pulses for one clk.
- All derived outputs are registered and computed from the next counter value, so in any cycle they describe the current pixelx/pixely (zero skew, zero latency).
- hsync = 0 when pixelx is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync = 0 when pixely is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- video_on = (pixelx < H_ACTIVE) and (pixely < V_ACTIVE).
- hit[i] = video_on and shadow_en[i] and sx <= pixelx <= sx+SPRITE_W-1 and sy <= pixely <= sy+SPRITE_H-1.
  - Compare in COORD_W+1 bits so sx+SPRITE_W never wraps.
  - Sprites crossing the right or bottom edge are clipped.
- sprite_addr[i] = (pixely-sy)*SPRITE_W + (pixelx-sx), truncated to ADDR_W, when hit[i]; 0 otherwise.
- Priority: sel_id = lowest i with hit[i]; sel_addr = sprite_addr[sel_id]; sel_valid = |hit. With no hit: sel_id = 0, sel_addr = 0.
- Mid-frame writes to sprite_x/y/en have no visible effect until the next frame_start.
- Reset mid-frame: immediate return to the reset state; the next frame starts at (0,0).

Decomposition:
- Package vga_pkg:
  - default timing constants
  - typedef coord_t (logic [COORD_W-1:0])
  - typedef sprite_addr_t
  - helper function h_total/v_total
- Sub-module vga_timing_counter: pixel/line counters, sync generation, video_on, frame_start.
- sprite_scan_gen instantiates vga_timing_counter and adds the shadow registers, per-sprite hit/address logic and the priority encoder.

Test Plan:
- Horizontal timing: release rst, pix_en = 1 every clk. Required: pixelx runs 0..799 and wraps to 0; pixely -> 1; hsync = 0 exactly for pixelx 656..751 (96 pix_en cycles).
- Vertical timing: run one full frame. Required: vsync = 0 on lines 490-491 only; frame_start pulses once per 420000 pix_en; video_on = 0 for x >= 640 or y >= 480.
- Single sprite: sprite 0 at (100,50), enabled, latched at frame_start. Required:
  - (100,50) -> hit0 = 1, addr 0
  - (163,113) -> addr 4095
  - (164,50) and (100,114) -> hit0 = 0
- Priority: sprites 0 and 1 both at (100,50). Required: sel_id = 0, sel_valid = 1. With sprite 0 disabled, sel_id = 1, sel_addr = sprite_addr[1].
- Shadow latch and clipping: set sprite_x[0] = 620 mid-frame. Required: hits stay at 100..163 until frame_start; next frame, hits only at x = 620..639, addr at (639,50) = 19.
- Enable gaps and reset: toggle pix_en 1-of-2. Required: counters advance only on enabled cycles. Assert rst mid-line: required: all outputs reach reset values immediately; counters resume from 0.
